// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with registered key strobe and held level.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int RELEASE_CYCLES = 256,
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_PERIOD  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RELEASE_MAX = RW'(RELEASE_CYCLES - 1);

  typedef enum logic {SCAN, HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [RW-1:0] rel_q, rel_d;
  logic [3:0]    cols_q, cols_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          one_low;
  logic [1:0]    row_idx;
  logic          advance;

  // Only a single closed row is a trustworthy key; anything else is a ghost or idle.
  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (rows)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int PW = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

  logic [PW-1:0] rpt_q, rpt_d;
  logic          armed_q, armed_d;
  logic [PW-1:0] rpt_nxt;
  logic [PW-1:0] rpt_thr;

  assign rpt_nxt = rpt_q + 1'b1;
  assign rpt_thr = armed_q ? PW'(REPEAT_PERIOD) : PW'(REPEAT_DELAY);
`endif

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    settle_d  = settle_q;
    rel_d     = rel_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    advance   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d     = rpt_q;
    armed_d   = armed_q;
`endif
    case (state_q)
      SCAN: begin
        if (settle_q == SETTLE_MAX) begin
          if (one_low) begin
            code_d   = {row_idx, col_idx_q};
            valid_d  = 1'b1;
            held_d   = 1'b1;
            settle_d = '0;
            rel_d    = '0;
            state_d  = HOLD;
`ifdef KEYPAD_REPEAT_EN
            rpt_d    = '0;
            armed_d  = 1'b0;
`endif
          end else begin
            advance = 1'b1;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      HOLD: begin
        if (rows == 4'hF) begin
`ifdef KEYPAD_REPEAT_EN
          rpt_d   = '0;
          armed_d = 1'b0;
`endif
          if (rel_q == RELEASE_MAX) begin
            held_d  = 1'b0;
            advance = 1'b1;
            state_d = SCAN;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end else begin
          rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
          if (rpt_nxt == rpt_thr) begin
            rpt_d   = '0;
            armed_d = 1'b1;
            valid_d = ~valid_q;
          end else begin
            rpt_d = rpt_nxt;
          end
`endif
        end
      end
      default: state_d = SCAN;
    endcase
    if (advance) begin
      col_idx_d = col_idx_q + 2'd1;
      settle_d  = '0;
    end
    cols_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      settle_q  <= '0;
      rel_q     <= '0;
      cols_q    <= 4'b1110;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      settle_q  <= settle_d;
      rel_q     <= rel_d;
      cols_q    <= cols_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      armed_q <= armed_d;
    end
  end
`endif

  assign cols      = cols_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a behavioural keypad matrix.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SETTLE  = 4;
  localparam int RELEASE = 8;
  localparam int RDELAY  = 20;
  localparam int RPERIOD = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  bit pressed [4][4];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // A closed switch pulls its row low only while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .RELEASE_CYCLES(RELEASE),
    .REPEAT_DELAY  (RDELAY),
    .REPEAT_PERIOD (RPERIOD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_keys;
    foreach (pressed[r, c]) pressed[r][c] = 1'b0;
  endtask

  task automatic restart;
    @(negedge clk);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] exp_cols;
    clear_keys();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (cols !== 4'b1110) begin n_err++; $display("FAIL reset_cols: got %b expected 1110", cols); end
    n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b expected 0", key_held); end
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k <= 4 * SETTLE + 4; k++) begin
      exp_cols = ~(4'b0001 << ((k / SETTLE) % 4));
      n_cmp++;
      if (cols !== exp_cols) begin n_err++; $display("FAIL scan_cols k=%0d: got %b expected %b", k, cols, exp_cols); end
      tick();
    end
  endtask

  task automatic test_single_press;
    int r, c, exp_k, first_k, nvalid;
    logic held_pre, held_post;
    for (int it = 0; it < 4; it++) begin
      r = (it == 0) ? 2 : int'($urandom_range(3, 0));
      c = (it == 0) ? 1 : int'($urandom_range(3, 0));
      clear_keys();
      restart();
      pressed[r][c] = 1'b1;
      exp_k = SETTLE * (c + 1);
      first_k = -1;
      nvalid = 0;
      for (int k = 0; k <= exp_k + 12; k++) begin
        if (key_valid === 1'b1) begin
          nvalid++;
          if (first_k < 0) first_k = k;
        end
        if (k == exp_k) begin
          n_cmp++; if (key_code !== 4'(r * 4 + c)) begin n_err++; $display("FAIL press_code: got %0d expected %0d", key_code, r * 4 + c); end
          n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL press_held: got %b expected 1", key_held); end
        end
        if (k < exp_k + 12) tick();
      end
      n_cmp++; if (first_k != exp_k) begin n_err++; $display("FAIL press_latency: got %0d expected %0d", first_k, exp_k); end
      n_cmp++; if (cols !== ~(4'b0001 << c)) begin n_err++; $display("FAIL press_cols_frozen: got %b expected %b", cols, ~(4'b0001 << c)); end
      clear_keys();
      held_pre = 1'b0;
      held_post = 1'b1;
      for (int n = 1; n <= RELEASE; n++) begin
        tick();
        if (key_valid === 1'b1) nvalid++;
        if (n == RELEASE - 1) held_pre = key_held;
        if (n == RELEASE) held_post = key_held;
      end
      n_cmp++; if (held_pre !== 1'b1) begin n_err++; $display("FAIL release_early: got %b expected 1", held_pre); end
      n_cmp++; if (held_post !== 1'b0) begin n_err++; $display("FAIL release_fall: got %b expected 0", held_post); end
      n_cmp++; if (cols !== ~(4'b0001 << ((c + 1) % 4))) begin n_err++; $display("FAIL release_cols: got %b expected %b", cols, ~(4'b0001 << ((c + 1) % 4))); end
      n_cmp++; if (key_code !== 4'(r * 4 + c)) begin n_err++; $display("FAIL release_code_kept: got %0d expected %0d", key_code, r * 4 + c); end
      n_cmp++; if (nvalid != 1) begin n_err++; $display("FAIL press_strobes: got %0d expected 1", nvalid); end
    end
  endtask

  task automatic test_ghost;
    int c, r1, r2, nvalid;
    logic [3:0] cols_after;
    for (int it = 0; it < 3; it++) begin
      c  = (it == 0) ? 0 : int'($urandom_range(3, 0));
      r1 = (it == 0) ? 0 : int'($urandom_range(3, 0));
      r2 = (it == 0) ? 2 : (r1 + 1 + int'($urandom_range(2, 0))) % 4;
      clear_keys();
      restart();
      pressed[r1][c] = 1'b1;
      pressed[r2][c] = 1'b1;
      nvalid = 0;
      cols_after = 4'h0;
      for (int k = 0; k <= 12 * SETTLE; k++) begin
        if (key_valid === 1'b1) nvalid++;
        if (k == SETTLE * (c + 1)) cols_after = cols;
        tick();
      end
      n_cmp++; if (cols_after !== ~(4'b0001 << ((c + 1) % 4))) begin n_err++; $display("FAIL ghost_advance: got %b expected %b", cols_after, ~(4'b0001 << ((c + 1) % 4))); end
      n_cmp++; if (nvalid != 0) begin n_err++; $display("FAIL ghost_strobes: got %0d expected 0", nvalid); end
      n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL ghost_held: got %b expected 0", key_held); end
      n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL ghost_code: got %0d expected 0", key_code); end
    end
    clear_keys();
  endtask

  task automatic test_release_glitch;
    int r, c, r2, k, nvalid;
    logic held_pre, held_post;
    r = int'($urandom_range(3, 0));
    c = int'($urandom_range(3, 0));
    r2 = (r + 1 + int'($urandom_range(2, 0))) % 4;
    clear_keys();
    restart();
    pressed[r][c] = 1'b1;
    k = 0;
    while (key_valid !== 1'b1 && k < 4 * SETTLE + 2) begin tick(); k++; end
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL glitch_detect: got %b expected 1 within %0d cycles", key_valid, 4 * SETTLE + 2); end
    nvalid = 0;
    pressed[r2][c] = 1'b1;
    repeat (3) begin tick(); if (key_valid === 1'b1) nvalid++; end
    clear_keys();
    repeat (5) begin tick(); if (key_valid === 1'b1) nvalid++; end
    pressed[r][c] = 1'b1;
    tick();
    if (key_valid === 1'b1) nvalid++;
    clear_keys();
    held_pre = 1'b0;
    held_post = 1'b1;
    for (int n = 1; n <= RELEASE; n++) begin
      tick();
      if (key_valid === 1'b1) nvalid++;
      if (n == RELEASE - 1) held_pre = key_held;
      if (n == RELEASE) held_post = key_held;
    end
    n_cmp++; if (held_pre !== 1'b1) begin n_err++; $display("FAIL glitch_held: got %b expected 1", held_pre); end
    n_cmp++; if (held_post !== 1'b0) begin n_err++; $display("FAIL glitch_fall: got %b expected 0", held_post); end
    n_cmp++; if (nvalid != 0) begin n_err++; $display("FAIL glitch_strobes: got %0d expected 0", nvalid); end
    n_cmp++; if (key_code !== 4'(r * 4 + c)) begin n_err++; $display("FAIL glitch_code: got %0d expected %0d", key_code, r * 4 + c); end
  endtask

  task automatic test_reset_mid_hold;
    int k, first_k, nvalid;
    clear_keys();
    restart();
    pressed[3][3] = 1'b1;
    k = 0;
    while (key_valid !== 1'b1 && k < 4 * SETTLE + 2) begin tick(); k++; end
    n_cmp++; if (key_code !== 4'd15) begin n_err++; $display("FAIL midhold_code: got %0d expected 15", key_code); end
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (cols !== 4'b1110) begin n_err++; $display("FAIL midhold_reset_cols: got %b expected 1110", cols); end
    n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL midhold_reset_code: got %0d expected 0", key_code); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL midhold_reset_held: got %b expected 0", key_held); end
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    first_k = -1;
    nvalid = 0;
    for (int j = 0; j <= 4 * SETTLE + 8; j++) begin
      if (key_valid === 1'b1) begin nvalid++; if (first_k < 0) first_k = j; end
      tick();
    end
    n_cmp++; if (first_k != 4 * SETTLE) begin n_err++; $display("FAIL midhold_redetect: got %0d expected %0d", first_k, 4 * SETTLE); end
    n_cmp++; if (nvalid != 1) begin n_err++; $display("FAIL midhold_strobes: got %0d expected 1", nvalid); end
    n_cmp++; if (key_code !== 4'd15) begin n_err++; $display("FAIL midhold_recode: got %0d expected 15", key_code); end
    clear_keys();
  endtask

  task automatic test_long_hold;
    int k;
    logic exp_v;
    clear_keys();
    restart();
    pressed[1][2] = 1'b1;
    k = 0;
    while (key_valid !== 1'b1 && k < 4 * SETTLE + 2) begin tick(); k++; end
    n_cmp++; if (key_code !== 4'd6) begin n_err++; $display("FAIL hold_code: got %0d expected 6", key_code); end
    for (int n = 1; n <= 45; n++) begin
      tick();
`ifdef KEYPAD_REPEAT_EN
      exp_v = (n >= RDELAY) && ((n - RDELAY) % RPERIOD == 0);
`else
      exp_v = 1'b0;
`endif
      n_cmp++;
      if (key_valid !== exp_v) begin n_err++; $display("FAIL hold_repeat n=%0d: got %b expected %b", n, key_valid, exp_v); end
    end
    n_cmp++; if (key_code !== 4'd6) begin n_err++; $display("FAIL hold_code_end: got %0d expected 6", key_code); end
    clear_keys();
  endtask

  initial begin
    clear_keys();
    test_reset();
    test_single_press();
    test_ghost();
    test_release_glitch();
    test_reset_mid_hold();
    test_long_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- 4x4 matrix keypad scanner; sits directly downstream of the per-row debounce2 instances and consumes their debounced row levels.
- Drives one column low at a time and samples the four debounced rows. Emits a 4-bit key code with a one-cycle valid strobe per press, plus a held level.
- Feeds the room-terminal input/command logic.

Parameters:
- SETTLE_CYCLES, 16: cycles a column is driven before rows are sampled (≥1); covers line settling plus debounce lag.
- RELEASE_CYCLES, 256: consecutive all-released cycles required to leave HOLD (≥1).
- REPEAT_DELAY, 25_000_000: cycles held before first auto-repeat (macro-gated).
- REPEAT_PERIOD, 5_000_000: cycles between subsequent auto-repeats (macro-gated).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous reset, active-low.
- rows  in  4  debounced row levels, active-low (0 = key closed on the driven column); bit i = row i.
- cols  out  4  column drive, active-low one-hot; bit j = column j.
- key_code  out  4  code of last accepted key = row*4 + col.
- key_valid  out  1  one-cycle strobe, key_code valid.
- key_held  out  1  high while the accepted key remains pressed.

Behaviour:
- Reset (async assert, sync-release use of state): state=SCAN, col_idx=0, cols=4'b1110, key_code=0, key_valid=0, key_held=0, all counters 0.
- All outputs are registered. cols is always exactly one bit low; it is never all-high and never has multiple bits low.
- SCAN:
  - Drive col_idx; settle_cnt counts 0..SETTLE_CYCLES-1.
  - Rows are sampled on the cycle settle_cnt==SETTLE_CYCLES-1.
  - Sample rows==4'hF: col_idx increments (3 wraps to 0), settle_cnt clears, stay in SCAN.
  - Sample with exactly one row bit low (row r): key_code<={r,col_idx}, key_valid=1 for exactly the next cycle, key_held=1, go HOLD. Column is NOT advanced.
  - Sample with ≥2 row bits low (ghost/multi-key): reject, no strobe, advance column as if released.
- HOLD:
  - Column stays driven. rel_cnt counts consecutive cycles with rows==4'hF; any low row clears rel_cnt.
  - When rel_cnt reaches RELEASE_CYCLES-1 with rows==4'hF: key_held<=0, col_idx advances, settle_cnt clears, go SCAN.
  - A second key pressed during HOLD is ignored (no strobe).
- Latency: press fully settled at start of column window → key_valid asserted SETTLE_CYCLES cycles after the column is driven. Worst-case detect after press ≈ 4*SETTLE_CYCLES + 1 cycles.
- key_valid never asserts in two consecutive cycles.
- key_code holds its value until the next accepted press. It is not cleared on release.
- reset_n asserted mid-HOLD or mid-SCAN: immediate return to reset values. No strobe on release of reset even if a key is down; the key is detected by normal scanning afterwards.
- Counter widths: $clog2 of the parameter, minimum 1 bit; counters saturate, never wrap.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - In HOLD, rpt_cnt counts held cycles (cleared by any released cycle).
  - At REPEAT_DELAY, then every REPEAT_PERIOD thereafter, key_valid pulses one cycle with key_code unchanged.
  - Repeat stops on release; rpt_cnt clears on entering HOLD.
- Not defined: no rpt_cnt logic exists; exactly one key_valid per press. REPEAT_* parameters are unused.

Test Plan:
- Reset: reset_n=0 → cols=4'b1110, key_code=0, key_valid=0, key_held=0. Release with rows=4'hF and SETTLE_CYCLES=4 → cols sequence 1110,1101,1011,0111,1110 with a 4-cycle dwell each.
- Single press: model key row2/col1 (rows[2]=0 only while cols[1]=0), SETTLE=4, RELEASE=8 → one key_valid pulse, key_code=9, key_held=1, cols frozen at 4'b1101. Release → key_held falls after 8 released cycles, cols advances to 4'b1011.
- Multi-key ghost: rows=4'b1010 while col0 driven → no key_valid, col advances to 4'b1101.
- Release glitch: in HOLD, release 5 cycles, re-press 1 cycle, release → key_held stays high until 8 consecutive released cycles. No second key_valid.
- Reset mid-HOLD: key row3/col3 held (code 15), reset_n pulsed low 2 cycles → outputs return to reset values immediately. Re-detection yields a single key_valid with key_code=15.
- KEYPAD_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10: hold key code 6 for 45 cycles → initial strobe plus repeats at held cycles 20, 30, 40, all with key_code=6. Without macro → single strobe.
